// File: rtl/prog_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the boot program loader.
// The slave modport is the loader's view; master is the source/memory side.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_wr, mem_waddr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_wr, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory, verifies an 8-bit checksum and releases the core.
module prog_loader #(
    parameter int unsigned          ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          MAX_WORDS = 4096
) (
    input  logic         CLK,
    input  logic         RST,
    prog_loader_if.slave bus,
    output logic         cpu_rst_n,
    output logic         load_done,
    output logic         load_err,
    output logic [31:0]  words_loaded
);
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          byte_cnt;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   word_total;
    logic [7:0]          sum;

    logic                accept;
    logic                last_byte;
    logic [WORD_W-1:0]   asm_word;
    logic [WORD_W-1:0]   words_inc;
    logic [7:0]          chk_sum;

    logic                byte_ready_d;
    logic                mem_wr_d;
    logic                cpu_rst_n_d;
    logic                load_done_d;
    logic                load_err_d;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign last_byte = accept && (byte_cnt == 2'd3);
    assign asm_word  = {bus.byte_data, shreg[WORD_W-1:8]};
    assign words_inc = words_loaded + 32'd1;
    assign chk_sum   = sum + bus.byte_data;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR: begin
                if (last_byte) begin
                    if (asm_word > WORD_W'(MAX_WORDS)) state_nxt = S_ERR;
                    else if (asm_word == '0)           state_nxt = S_CHK;
                    else                               state_nxt = S_DATA;
                end
            end
            S_DATA:  if (last_byte) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (words_inc == word_total) ? S_CHK : S_DATA;
            S_CHK: begin
                if (accept) state_nxt = (chk_sum == 8'd0) ? S_DONE : S_ERR;
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_HDR;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        byte_ready_d = 1'b0;
        mem_wr_d     = 1'b0;
        cpu_rst_n_d  = 1'b0;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
        case (state_nxt)
            S_HDR, S_DATA, S_CHK: byte_ready_d = 1'b1;
            S_WRITE:              mem_wr_d     = 1'b1;
            S_DONE: begin
                cpu_rst_n_d = 1'b1;
                load_done_d = 1'b1;
            end
            S_ERR:                load_err_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.byte_ready <= 1'b0;
            bus.mem_wr     <= 1'b0;
            cpu_rst_n      <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            bus.byte_ready <= byte_ready_d;
            bus.mem_wr     <= mem_wr_d;
            cpu_rst_n      <= cpu_rst_n_d;
            load_done      <= load_done_d;
            load_err       <= load_err_d;
        end
    end

    // Byte assembly, running checksum, word count and write payload
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            byte_cnt      <= '0;
            shreg         <= '0;
            word_total    <= '0;
            sum           <= '0;
            words_loaded  <= '0;
            bus.mem_waddr <= BASE_ADDR;
            bus.mem_wdata <= '0;
        end else begin
            if (accept && (state == S_HDR || state == S_DATA)) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= asm_word;
                sum      <= chk_sum;
            end
            if (last_byte && state == S_HDR) begin
                word_total <= asm_word;
            end
            if (last_byte && state == S_DATA) begin
                bus.mem_wdata <= asm_word;
                bus.mem_waddr <= BASE_ADDR + (ADDR_W'(words_loaded) << 2);
            end
            if (state == S_WRITE) begin
                words_loaded <= words_inc;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of whole-image streams plus reset corner sequences,
// with a scoreboard of expected memory writes.
module tb_prog_loader;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned MAXW   = 4096;
    localparam int unsigned NVEC   = 6;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;
    logic [31:0] words_loaded;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR('0),
        .MAX_WORDS(MAXW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus.slave),
        .cpu_rst_n   (cpu_rst_n),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct packed {
        logic [0:15][7:0] b;
        logic [31:0]      len;
        logic             throttle;
        logic             done;
        logic             err;
        logic [31:0]      words;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tv[NVEC];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every write strobe must match the next expected word
    always @(negedge CLK) begin
        if (RST && bus.mem_wr) begin
            if (exp_q.size() == 0) begin
                check("mem_wr unexpected", 64'(bus.mem_wr), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("mem_waddr", 64'(bus.mem_waddr), 64'(e.addr));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d);
        int t;
        t = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        while (!bus.byte_ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) check("byte_ready timeout", 64'(bus.byte_ready), 64'd1);
        else @(negedge CLK);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    // Drives a stream and pushes the words a correct loader must write
    task automatic send_stream(input logic [0:15][7:0] b, input int len, input bit throttle);
        longint unsigned n;
        logic [31:0]     w;
        int              j;
        n = 0;
        w = '0;
        for (int i = 0; i < len; i++) begin
            if (throttle) repeat (1 + $urandom_range(0, 5)) @(negedge CLK);
            j = i - 4;
            if (i < 4) begin
                n[i*8 +: 8] = b[i];
            end else if (n <= MAXW && longint'(j) < 4 * n) begin
                w[(j % 4)*8 +: 8] = b[i];
                if (j % 4 == 3) exp_q.push_back('{addr: ADDR_W'(j / 4 * 4), data: w});
            end
            send_byte(b[i]);
            if (i >= 4 && n <= MAXW && longint'(j) < 4 * n && j % 4 == 3)
                check("mem_wr latency", 64'(bus.mem_wr), 64'd1);
            if (i == 3 && n > MAXW)
                check("err after header", 64'(load_err), 64'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        bus.byte_valid = 1'b0;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        exp_q.delete();
        RST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        logic [0:15][7:0] nominal;
        nominal = {8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'hA0, 8'h00, 8'h67, 8'h00, 8'h00, 8'h00};

        tv[0] = '{b: nominal, len: 13, throttle: 1'b0, done: 1'b1, err: 1'b0, words: 2};
        tv[1] = '{b: '0, len: 5, throttle: 1'b0, done: 1'b1, err: 1'b0, words: 0};
        tv[2] = '{b: nominal, len: 13, throttle: 1'b0, done: 1'b0, err: 1'b1, words: 2};
        tv[2].b[12] = 8'h68;
        tv[3] = '{b: {8'h01, 8'h10, 8'h00, 8'h00, 96'h0}, len: 4, throttle: 1'b0,
                  done: 1'b0, err: 1'b1, words: 0};
        tv[4] = '{b: nominal, len: 13, throttle: 1'b1, done: 1'b1, err: 1'b0, words: 2};
        tv[5] = '{b: {8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC7, 56'h0},
                  len: 9, throttle: 1'b0, done: 1'b1, err: 1'b0, words: 1};

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #1 RST = 1'b0;
        #2;
        check("rst byte_ready", 64'(bus.byte_ready), 64'd0);
        check("rst mem_wr", 64'(bus.mem_wr), 64'd0);
        check("rst mem_waddr", 64'(bus.mem_waddr), 64'd0);
        check("rst mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("rst load_done", 64'(load_done), 64'd0);
        check("rst load_err", 64'(load_err), 64'd0);
        check("rst words_loaded", 64'(words_loaded), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("byte_ready after release", 64'(bus.byte_ready), 64'd1);

        for (int v = 0; v < int'(NVEC); v++) begin
            do_reset();
            send_stream(tv[v].b, int'(tv[v].len), tv[v].throttle);
            repeat (2) @(negedge CLK);
            check($sformatf("v%0d load_done", v), 64'(load_done), 64'(tv[v].done));
            check($sformatf("v%0d load_err", v), 64'(load_err), 64'(tv[v].err));
            check($sformatf("v%0d cpu_rst_n", v), 64'(cpu_rst_n), 64'(tv[v].done));
            check($sformatf("v%0d words_loaded", v), 64'(words_loaded), 64'(tv[v].words));
            check($sformatf("v%0d byte_ready", v), 64'(bus.byte_ready), 64'd0);
            check($sformatf("v%0d writes pending", v), 64'(exp_q.size()), 64'd0);
            // A byte offered in a terminal state must be ignored
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'h55;
            repeat (4) @(negedge CLK);
            check($sformatf("v%0d terminal byte_ready", v), 64'(bus.byte_ready), 64'd0);
            check($sformatf("v%0d terminal done", v), 64'(load_done), 64'(tv[v].done));
            check($sformatf("v%0d terminal err", v), 64'(load_err), 64'(tv[v].err));
            check($sformatf("v%0d terminal words", v), 64'(words_loaded), 64'(tv[v].words));
            bus.byte_valid = 1'b0;
        end

        // Reset in the middle of a load, after the first word has been written
        do_reset();
        send_stream(nominal, 8, 1'b0);
        @(negedge CLK);
        check("midrst words before", 64'(words_loaded), 64'd1);
        check("midrst cpu before", 64'(cpu_rst_n), 64'd0);
        #2 RST = 1'b0;
        #1;
        check("midrst cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("midrst words_loaded", 64'(words_loaded), 64'd0);
        check("midrst byte_ready", 64'(bus.byte_ready), 64'd0);
        check("midrst mem_wr", 64'(bus.mem_wr), 64'd0);
        @(negedge CLK);
        exp_q.delete();
        RST = 1'b1;
        @(negedge CLK);
        send_stream(nominal, 13, 1'b0);
        repeat (2) @(negedge CLK);
        check("reload load_done", 64'(load_done), 64'd1);
        check("reload cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        check("reload words_loaded", 64'(words_loaded), 64'd2);
        check("reload load_err", 64'(load_err), 64'd0);
        check("reload writes pending", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
